// File: rtl/axil_master_port.sv
`default_nettype none
// ============================================================================
// Module   : axil_master_port
// Brief    : Single-outstanding core request/response to AXI-Lite initiator.
//            Optional AXIL_MASTER_ALIGN_CHECK_EN rejects misaligned requests.
// Revision : 1.0 - initial release
// ============================================================================
module axil_master_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    // core side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [1:0]            req_size,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    // AXI-Lite read channels
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    // AXI-Lite write channels
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int c_strb_w = DATA_W / 8;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_raddr = 3'd1;
    localparam logic [2:0] c_st_rdata = 3'd2;
    localparam logic [2:0] c_st_wreq  = 3'd3;
    localparam logic [2:0] c_st_wresp = 3'd4;
    localparam logic [2:0] c_st_rsp   = 3'd5;

    logic [2:0]          r_state,     w_state_nxt;
    logic [ADDR_W-1:0]   r_araddr,    w_araddr_nxt;
    logic                r_arvalid,   w_arvalid_nxt;
    logic                r_rready,    w_rready_nxt;
    logic [ADDR_W-1:0]   r_awaddr,    w_awaddr_nxt;
    logic                r_awvalid,   w_awvalid_nxt;
    logic [DATA_W-1:0]   r_wdata,     w_wdata_nxt;
    logic [c_strb_w-1:0] r_wstrb,     w_wstrb_nxt;
    logic                r_wvalid,    w_wvalid_nxt;
    logic                r_bready,    w_bready_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic                r_rsp_err,   w_rsp_err_nxt;

    logic w_misaligned;
    logic w_aw_done;
    logic w_w_done;

    // Only the error bit of xRESP matters: OKAY and EXOKAY are both success.
    logic w_unused_resp;
    assign w_unused_resp = rresp[0] ^ bresp[0];

`ifdef AXIL_MASTER_ALIGN_CHECK_EN
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = req_addr[0];
            2'd2:    w_misaligned = (req_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end
`else
    logic w_unused_size;
    assign w_unused_size = ^req_size;
    assign w_misaligned  = 1'b0;
`endif

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign w_aw_done = ~r_awvalid | awready;
    assign w_w_done  = ~r_wvalid  | wready;

    always_comb begin
        w_state_nxt     = r_state;
        w_araddr_nxt    = r_araddr;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_awaddr_nxt    = r_awaddr;
        w_awvalid_nxt   = r_awvalid;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            c_st_idle: begin
                if (req_valid) begin
                    if (w_misaligned) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                        w_state_nxt     = c_st_rsp;
                    end else if (req_we) begin
                        w_awaddr_nxt  = req_addr;
                        w_wdata_nxt   = req_wdata;
                        w_wstrb_nxt   = req_wstrb;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = c_st_wreq;
                    end else begin
                        w_araddr_nxt  = req_addr;
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = c_st_raddr;
                    end
                end
            end

            c_st_raddr: begin
                if (arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = c_st_rdata;
                end
            end

            c_st_rdata: begin
                if (rvalid) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = rdata;
                    w_rsp_err_nxt   = rresp[1];
                    w_state_nxt     = c_st_rsp;
                end
            end

            c_st_wreq: begin
                if (r_awvalid && awready) begin
                    w_awvalid_nxt = 1'b0;
                end
                if (r_wvalid && wready) begin
                    w_wvalid_nxt = 1'b0;
                end
                if (w_aw_done && w_w_done) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = c_st_wresp;
                end
            end

            c_st_wresp: begin
                if (bvalid) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = bresp[1];
                    w_state_nxt     = c_st_rsp;
                end
            end

            c_st_rsp: begin
                // Return every output to zero so IDLE presents a quiet bus.
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                    w_araddr_nxt    = '0;
                    w_awaddr_nxt    = '0;
                    w_wdata_nxt     = '0;
                    w_wstrb_nxt     = '0;
                    w_state_nxt     = c_st_idle;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_araddr    <= w_araddr_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign req_ready = (r_state == c_st_idle);
    assign araddr    = r_araddr;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;
    assign awaddr    = r_awaddr;
    assign awvalid   = r_awvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_axil_master_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_master_port
// Brief    : Randomized scoreboard bench for axil_master_port with a scripted
//            AXI-Lite responder; honours AXIL_MASTER_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_master_port;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [1:0]          req_size = '0;
    logic [DATA_W-1:0]   req_wdata = '0;
    logic [DATA_W/8-1:0] req_wstrb = '0;
    logic                rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [ADDR_W-1:0]   araddr, awaddr;
    logic                arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic [DATA_W-1:0]   rdata = '0, wdata;
    logic [1:0]          rresp = '0, bresp = '0;
    logic                awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid = 1'b0, bready;

    axil_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          ar_w, r_w, aw_w, w_w, b_w, bp;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          accept;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic bit misaligned(input logic [31:0] addr, input logic [1:0] size);
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1) return (addr % 2) != 0;
        if (size == 2'd2) return (addr % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // Expected response and handshake latency straight from the protocol rules.
    function automatic exp_t ref_model(input txn_t t, input int acc);
        exp_t e;
        int   wr_wait;
        e.accept = acc;
        if (misaligned(t.addr, t.size)) begin
            e.rdata = '0;
            e.err   = 1'b1;
            e.lat   = 1 + t.bp;
        end else if (t.we) begin
            wr_wait = (t.aw_w > t.w_w) ? t.aw_w : t.w_w;
            e.rdata = '0;
            e.err   = t.resp[1];
            e.lat   = 3 + wr_wait + t.b_w + t.bp;
        end else begin
            e.rdata = t.rdata;
            e.err   = t.resp[1];
            e.lat   = 3 + t.ar_w + t.r_w + t.bp;
        end
        return e;
    endfunction

    function automatic txn_t mk(input bit we, input logic [31:0] addr, input logic [1:0] size,
                                input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd,
                                input logic [1:0] resp, input int ar_w, input int r_w,
                                input int aw_w, input int w_w, input int b_w, input int bp);
        txn_t t;
        t.we = we; t.addr = addr; t.size = size; t.wdata = wd; t.wstrb = ws;
        t.rdata = rd; t.resp = resp; t.ar_w = ar_w; t.r_w = r_w;
        t.aw_w = aw_w; t.w_w = w_w; t.b_w = b_w; t.bp = bp;
        return t;
    endfunction

    task automatic run_txn(input txn_t t);
        exp_t e;
        int   n;
        chk("req_ready_idle", req_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
        req_valid = 1'b1; req_we = t.we; req_addr = t.addr; req_size = t.size;
        req_wdata = t.wdata; req_wstrb = t.wstrb;
        e = ref_model(t, cyc);
        exp_q.push_back(e);
        tick;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = $urandom;
        if (!misaligned(t.addr, t.size)) begin
            if (!t.we) begin
                for (int i = 0; i <= t.ar_w; i++) begin
                    chk("arvalid", arvalid, 1);
                    chk("araddr", araddr, t.addr);
                    chk("rready_early", rready, 0);
                    arready = (i == t.ar_w);
                    tick;
                end
                arready = 1'b0;
                for (int i = 0; i <= t.r_w; i++) begin
                    chk("rready", rready, 1);
                    chk("arvalid_after", arvalid, 0);
                    rvalid = (i == t.r_w);
                    rdata  = (i == t.r_w) ? t.rdata : $urandom;
                    rresp  = (i == t.r_w) ? t.resp : 2'($urandom);
                    tick;
                end
                rvalid = 1'b0;
            end else begin
                n = ((t.aw_w > t.w_w) ? t.aw_w : t.w_w) + 1;
                for (int j = 0; j < n; j++) begin
                    chk("awvalid", awvalid, (j <= t.aw_w));
                    chk("wvalid", wvalid, (j <= t.w_w));
                    if (j <= t.aw_w) chk("awaddr", awaddr, t.addr);
                    if (j <= t.w_w) chk("wdata_wstrb", {wstrb, wdata}, {t.wstrb, t.wdata});
                    chk("bready_early", bready, 0);
                    awready = (j == t.aw_w);
                    wready  = (j == t.w_w);
                    tick;
                end
                awready = 1'b0; wready = 1'b0;
                for (int i = 0; i <= t.b_w; i++) begin
                    chk("bready", bready, 1);
                    chk("aw_w_dropped", {awvalid, wvalid}, 0);
                    bvalid = (i == t.b_w);
                    bresp  = (i == t.b_w) ? t.resp : 2'($urandom);
                    tick;
                end
                bvalid = 1'b0;
            end
        end
        for (int k = 0; k <= t.bp; k++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_hold", {rsp_err, rsp_rdata}, {e.err, e.rdata});
            chk("req_ready_busy", req_ready, 0);
            chk("axi_quiet", {arvalid, awvalid, wvalid, rready, bready}, 0);
            rsp_ready = (k == t.bp);
            tick;
        end
        rsp_ready = 1'b0;
    endtask

    // Scoreboard monitor: compares each accepted response against the queue.
    exp_t mon_e;
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rsp handshake, required none pending (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_rdata", rsp_rdata, mon_e.rdata);
                chk("sb_err", rsp_err, mon_e.err);
                chk("sb_latency", cyc - mon_e.accept, mon_e.lat);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_err}, 0);
        chk("rst_addr", {araddr, awaddr}, 0);
        chk("rst_data", {rsp_rdata, wdata, 28'h0, wstrb}, 0);

        run_txn(mk(0, 32'h8000_0004, 2, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0));
        run_txn(mk(1, 32'h8000_0010, 2, 32'h1234_5678, 4'b0011, 0, 2'b00, 0, 0, 2, 0, 0, 0));
        run_txn(mk(0, 32'h8000_0020, 2, 0, 0, 32'hA5A5_0001, 2'b10, 1, 0, 0, 0, 0, 0));
        run_txn(mk(1, 32'h8000_0024, 2, 32'hCAFE_F00D, 4'b1111, 0, 2'b11, 0, 0, 0, 3, 1, 0));
        run_txn(mk(0, 32'h8000_0028, 2, 0, 0, 32'h0BAD_CAFE, 2'b00, 0, 2, 0, 0, 0, 0));
        run_txn(mk(0, 32'h8000_002C, 2, 0, 0, 32'h1357_9BDF, 2'b01, 0, 0, 0, 0, 0, 4));
        run_txn(mk(0, 32'h8000_0002, 2, 0, 0, 32'h2468_ACE0, 2'b00, 0, 0, 0, 0, 0, 0));
        run_txn(mk(1, 32'h8000_0003, 1, 32'h0000_BEEF, 4'b1000, 0, 2'b00, 0, 0, 1, 1, 0, 1));

        // Reset while AR is waiting on arready.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0040; req_size = 2'd2;
        tick;
        req_valid = 1'b0;
        chk("mid_arvalid_before", arvalid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_arvalid_async", arvalid, 0);
        chk("mid_req_ready_async", req_ready, 1);
        tick;
        reset = 1'b0;
        tick;
        chk("mid_req_ready_after", req_ready, 1);
        chk("mid_rsp_valid_after", rsp_valid, 0);

        for (int i = 0; i < 200; i++) begin
            t = mk($urandom_range(0, 1), $urandom, 2'($urandom_range(0, 3)), $urandom,
                   4'($urandom), $urandom, 2'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
            if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
            run_txn(t);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL pending_rsp: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_master_port.md
# axil_master_port

AXI-Lite initiator port that turns a simple single-outstanding core-side request/response interface into AXI-Lite read (AR/R) and write (AW/W/B) transactions. It sits between a CPU-side fetch/load-store unit and the AXI-Lite bus that feeds `SRAM_AXI` or any other AXI-Lite responder. It drives the same channel signal set the responders already expose. Only one transaction is outstanding at a time.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `wstrb` is `DATA_W/8` bits

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  core request valid
- `req_ready`  out  1  core request accepted when `req_valid & req_ready`
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  byte address
- `req_size`  in  2  0 = byte, 1 = half, 2 = word
- `req_wdata`  in  DATA_W  write data
- `req_wstrb`  in  DATA_W/8  write byte strobes
- `rsp_valid`  out  1  response valid; held until `rsp_ready`
- `rsp_ready`  in  1  core accepts response
- `rsp_rdata`  out  DATA_W  read data; 0 for writes
- `rsp_err`  out  1  1 = SLVERR, DECERR, or alignment error
- AXI-Lite master channels:
  - `araddr`  out  ADDR_W
  - `arvalid`  out  1
  - `arready`  in  1
  - `rdata`  in  DATA_W
  - `rresp`  in  2
  - `rvalid`  in  1
  - `rready`  out  1
  - `awaddr`  out  ADDR_W
  - `awvalid`  out  1
  - `awready`  in  1
  - `wdata`  out  DATA_W
  - `wstrb`  out  DATA_W/8
  - `wvalid`  out  1
  - `wready`  in  1
  - `bresp`  in  2
  - `bvalid`  in  1
  - `bready`  out  1

## Operation
States: IDLE, RADDR, RDATA, WREQ, WRESP, RSP.

- **IDLE**
  - `req_ready` = 1; all other outputs are 0.
  - On request handshake, latch addr/size/wdata/wstrb/we, then go to RADDR (read) or WREQ (write).
- **RADDR**
  - `arvalid` = 1; `araddr` is held stable.
  - On `arready`, go to RDATA.
- **RDATA**
  - `rready` = 1.
  - On `rvalid`, latch `rdata`, set `rsp_err = rresp[1]`, and go to RSP.
- **WREQ**
  - `awvalid` and `wvalid` are asserted together on entry.
  - Each drops independently after its own handshake and is never reasserted within the transaction.
  - Go to WRESP when both handshakes have completed, including the case where both complete in the same cycle.
- **WRESP**
  - `bready` = 1.
  - On `bvalid`, set `rsp_err = bresp[1]`, set `rsp_rdata = 0`, and go to RSP.
- **RSP**
  - `rsp_valid` = 1 with stable data.
  - On `rsp_ready`, go to IDLE.

General rules:
- All AXI outputs and `rsp_*` are registered; no combinational path from AXI inputs to AXI outputs.
- `req_ready` is decoded from state only.
- Responses with `xRESP[1] = 0` (OKAY, EXOKAY) are reported as success.

## Timing
- **Reset values:** state IDLE; `arvalid`, `rready`, `awvalid`, `wvalid`, `bready`, `rsp_valid`, `rsp_err` = 0; `rsp_rdata` and all address/data outputs = 0; `req_ready` = 1.
- **Read, zero-wait responder:**
  - Request handshake at cycle 0.
  - `arvalid` high in cycle 1 (AR handshake if `arready`=1).
  - `rready` high in cycle 2.
  - `rsp_valid` in cycle 3 when `rvalid` is in cycle 2.
  - Minimum latency is 3 cycles.
- **Write, zero-wait responder:**
  - AW and W valid in cycle 1.
  - `bready` in cycle 2.
  - `rsp_valid` in cycle 3.
- **Wait states:** each wait cycle on `arready`, `rvalid`, `awready`/`wready` (the later of the two), or `bvalid` adds exactly one cycle.
- **Back-to-back requests:** a new request is accepted in the cycle after the RSP handshake; there is no overlap.
- **Stability:** valids never deassert before their handshake, and the associated payload is stable while valid is high.
- **Reset mid-transaction:** all valids/readies drop asynchronously, the FSM returns to IDLE, and any pending response is discarded.

## Configuration
- Macro: `AXIL_MASTER_ALIGN_CHECK_EN`.
- **Defined:** misaligned requests are detected in IDLE at acceptance.
  - Misaligned means: size 1 with `addr[0]=1`; size 2 with `addr[1:0]!=0`; size 3 always.
  - A misaligned request goes directly to RSP with `rsp_err=1` and `rsp_rdata=0`.
  - No AXI channel is asserted for it.
  - Response latency is 1 cycle.
- **Undefined:** `req_size` is ignored, every request is issued on the bus unmodified, and `rsp_err` reflects only `xRESP`.

## Test plan
- **Read, zero-wait:** read addr 0x8000_0004 with responder returning 0xDEADBEEF, OKAY, zero wait -> `araddr`=0x8000_0004 in cycle 1, `rsp_valid` in cycle 3 with `rsp_rdata`=0xDEADBEEF and `rsp_err`=0.
- **Write, split handshakes:** write 0x1234_5678, `wstrb`=4'b0011 to 0x8000_0010; `awready` delayed 2 cycles, `wready` immediate -> `wvalid` drops after cycle 1, `awvalid` holds until cycle 3, `bready` in cycle 4, `rsp_valid` in cycle 5.
- **Error responses:** read with `rresp`=2'b10, then a write with `bresp`=2'b11 -> `rsp_err`=1 for both, and a subsequent OKAY read reports `rsp_err`=0.
- **Response backpressure:** hold `rsp_ready`=0 for 4 cycles -> `rsp_valid` and `rsp_rdata` stable, `req_ready`=0, and no AXI valid asserted throughout.
- **Reset mid-transaction:** assert `reset` while `arvalid`=1 and `arready`=0 -> `arvalid` goes to 0 immediately, and after release `req_ready`=1 and `rsp_valid`=0.
- **Alignment check, `AXIL_MASTER_ALIGN_CHECK_EN` defined:** word read at 0x8000_0002 -> `rsp_err`=1 one cycle after acceptance with no `arvalid`. Undefined: same stimulus issues `araddr`=0x8000_0002.
